ex_hazard_ctrl: RTL and testbench

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Hazard and freeze control for a 5-stage pipeline: load-use bubbles, redirect flushes,
// memory-busy freezes, and saturating stall/flush event counters.
module ex_hazard_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_rd,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_UsesRt,
  input  logic        EX_Redirect,
  input  logic        MemBusy,
  input  logic        CntClear,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        PipeFreeze,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    FLUSH  = 2'b10,
    HOLD   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_FREEZE,
    EV_REDIRECT,
    EV_STALL
  } event_t;

  state_t state;
  state_t next_state;
  state_t ret_state;
  state_t eff_state;
  event_t ev;
  logic   load_use;
  logic   stall_inc;
  logic   flush_inc;

  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == IF_ID_rs) || (IF_ID_UsesRt && (ID_EX_rd == IF_ID_rt)));

  // On release from HOLD the FSM behaves exactly as the state it froze in.
  assign eff_state = (state == HOLD) ? ret_state : state;

  // Prioritised event decode shared by next-state and output logic.
  always_comb begin
    ev = EV_NONE;
    if (Reset)
      ev = EV_NONE;
    else if (MemBusy)
      ev = EV_FREEZE;
    else if (EX_Redirect)
      ev = EV_REDIRECT;
    else if (load_use && (eff_state == RUN))
      ev = EV_STALL;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RUN;
      ret_state <= RUN;
    end else begin
      state <= next_state;
      // A freeze that extends an existing HOLD keeps the originally saved state.
      if (MemBusy && (state != HOLD))
        ret_state <= state;
    end
  end

  always_comb begin
    next_state = RUN;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    unique case (ev)
      EV_FREEZE:   next_state = HOLD;
      EV_REDIRECT: begin
        next_state = FLUSH;
        flush_inc  = 1'b1;
      end
      EV_STALL: begin
        next_state = BUBBLE;
        stall_inc  = 1'b1;
      end
      default:     next_state = RUN;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    PipeFreeze  = 1'b0;
    unique case (ev)
      EV_FREEZE: begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        PipeFreeze  = 1'b1;
      end
      EV_REDIRECT: begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      EV_STALL: begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || CntClear)
      StallCount <= '0;
    else if (stall_inc && (StallCount != '1))
      StallCount <= StallCount + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset || CntClear)
      FlushCount <= '0;
    else if (flush_inc && (FlushCount != '1))
      FlushCount <= FlushCount + 16'd1;
  end

  assign State = state;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed-vector bench for ex_hazard_ctrl with hand-computed expectations.
module tb_ex_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        IF_ID_UsesRt;
  logic        EX_Redirect;
  logic        MemBusy;
  logic        CntClear;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        PipeFreeze;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
  logic [1:0]  State;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ex_hazard_ctrl dut (
    .Clk(Clk), .Reset(Reset), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .EX_Redirect(EX_Redirect), .MemBusy(MemBusy), .CntClear(CntClear),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .PipeFreeze(PipeFreeze), .StallCount(StallCount),
    .FlushCount(FlushCount), .State(State)
  );

  always #5 Clk = ~Clk;

  // Advance one edge, then settle so registered outputs can be sampled.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
    IF_ID_UsesRt = 1'b0; EX_Redirect = 1'b0; MemBusy = 1'b0; CntClear = 1'b0;
  endtask

  task automatic set_load_use();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs = 5'd5; IF_ID_rt = 5'd9; IF_ID_UsesRt = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1; MemBusy = 1'b1; EX_Redirect = 1'b1;
    #1;
    total++;
    if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze} !== 5'b11000) begin
      bad++; $display("FAIL reset_comb got=%b exp=11000", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze});
    end
    tick();
    total++;
    if (State !== 2'b00 || StallCount !== 16'd0 || FlushCount !== 16'd0) begin
      bad++; $display("FAIL reset_state state=%b stall=%h flush=%h exp 00/0000/0000", State, StallCount, FlushCount);
    end
    Reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    total++;
    if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze} !== 5'b00010) begin
      bad++; $display("FAIL lu_stall got=%b exp=00010", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze});
    end
    tick();
    total++;
    if (State !== 2'b01 || StallCount !== 16'd1) begin
      bad++; $display("FAIL lu_bubble state=%b stall=%h exp 01/0001", State, StallCount);
    end
    total++;
    if ({PCWrite, IF_ID_Write, ID_EX_Flush} !== 3'b110) begin
      bad++; $display("FAIL lu_bubble_out got=%b exp=110", {PCWrite, IF_ID_Write, ID_EX_Flush});
    end
    idle_inputs();
    tick();
    total++;
    if (State !== 2'b00 || StallCount !== 16'd1) begin
      bad++; $display("FAIL lu_back_run state=%b stall=%h exp 00/0001", State, StallCount);
    end
  endtask

  task automatic test_gating();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; IF_ID_UsesRt = 1'b1;
    #1;
    total++;
    if (PCWrite !== 1'b1 || ID_EX_Flush !== 1'b0) begin
      bad++; $display("FAIL gate_r0 pcw=%b idexf=%b exp 1/0", PCWrite, ID_EX_Flush);
    end
    ID_EX_rd = 5'd7; IF_ID_rs = 5'd3; IF_ID_rt = 5'd7; IF_ID_UsesRt = 1'b0;
    #1;
    total++;
    if (PCWrite !== 1'b1 || ID_EX_Flush !== 1'b0) begin
      bad++; $display("FAIL gate_rt_unused pcw=%b idexf=%b exp 1/0", PCWrite, ID_EX_Flush);
    end
    IF_ID_UsesRt = 1'b1;
    #1;
    total++;
    if (PCWrite !== 1'b0 || ID_EX_Flush !== 1'b1) begin
      bad++; $display("FAIL gate_rt_used pcw=%b idexf=%b exp 0/1", PCWrite, ID_EX_Flush);
    end
    ID_EX_MemRead = 1'b0;
    #1;
    total++;
    if (PCWrite !== 1'b1) begin
      bad++; $display("FAIL gate_noread pcw=%b exp 1", PCWrite);
    end
    tick();
    total++;
    if (State !== 2'b00 || StallCount !== 16'd0) begin
      bad++; $display("FAIL gate_state state=%b stall=%h exp 00/0000", State, StallCount);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    set_load_use();
    EX_Redirect = 1'b1;
    #1;
    total++;
    if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze} !== 5'b11110) begin
      bad++; $display("FAIL redir_out got=%b exp=11110", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze});
    end
    tick();
    total++;
    if (State !== 2'b10 || FlushCount !== 16'd1 || StallCount !== 16'd0) begin
      bad++; $display("FAIL redir_state state=%b flush=%h stall=%h exp 10/0001/0000", State, FlushCount, StallCount);
    end
    EX_Redirect = 1'b0;
    #1;
    total++;
    if ({PCWrite, IF_ID_Write, ID_EX_Flush} !== 3'b110) begin
      bad++; $display("FAIL flush_no_stall got=%b exp=110", {PCWrite, IF_ID_Write, ID_EX_Flush});
    end
    tick();
    total++;
    if (State !== 2'b00 || StallCount !== 16'd0) begin
      bad++; $display("FAIL flush_to_run state=%b stall=%h exp 00/0000", State, StallCount);
    end
    idle_inputs();
  endtask

  task automatic test_membusy_hold();
    do_reset();
    set_load_use();
    MemBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze} !== 5'b00001) begin
        bad++; $display("FAIL hold_out[%0d] got=%b exp=00001", i, {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze});
      end
      tick();
      total++;
      if (State !== 2'b11 || StallCount !== 16'd0) begin
        bad++; $display("FAIL hold_state[%0d] state=%b stall=%h exp 11/0000", i, State, StallCount);
      end
    end
    MemBusy = 1'b0;
    #1;
    total++;
    if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze} !== 5'b00010) begin
      bad++; $display("FAIL release_stall got=%b exp=00010", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze});
    end
    tick();
    total++;
    if (State !== 2'b01 || StallCount !== 16'd1) begin
      bad++; $display("FAIL release_bubble state=%b stall=%h exp 01/0001", State, StallCount);
    end
    // Freeze inside BUBBLE: on release the return state must suppress a second stall.
    MemBusy = 1'b1;
    tick();
    tick();
    MemBusy = 1'b0;
    #1;
    total++;
    if ({PCWrite, ID_EX_Flush, PipeFreeze} !== 3'b100) begin
      bad++; $display("FAIL release_from_bubble got=%b exp=100", {PCWrite, ID_EX_Flush, PipeFreeze});
    end
    tick();
    total++;
    if (State !== 2'b00 || StallCount !== 16'd1) begin
      bad++; $display("FAIL release_bubble_run state=%b stall=%h exp 00/0001", State, StallCount);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    EX_Redirect = 1'b1;
    tick();
    EX_Redirect = 1'b0;
    MemBusy = 1'b1;
    tick();
    total++;
    if (State !== 2'b11 || FlushCount !== 16'd1) begin
      bad++; $display("FAIL rh_pre state=%b flush=%h exp 11/0001", State, FlushCount);
    end
    Reset = 1'b1;
    #1;
    total++;
    if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze} !== 5'b11000) begin
      bad++; $display("FAIL rh_comb got=%b exp=11000", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze});
    end
    tick();
    total++;
    if (State !== 2'b00 || FlushCount !== 16'd0 || StallCount !== 16'd0) begin
      bad++; $display("FAIL rh_after state=%b flush=%h stall=%h exp 00/0000/0000", State, FlushCount, StallCount);
    end
    Reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_load_use();
    tick();
    tick();
    total++;
    if (State !== 2'b00 || PCWrite !== 1'b0 || ID_EX_Flush !== 1'b1) begin
      bad++; $display("FAIL b2b_restall state=%b pcw=%b idexf=%b exp 00/0/1", State, PCWrite, ID_EX_Flush);
    end
    tick();
    total++;
    if (State !== 2'b01 || StallCount !== 16'd2) begin
      bad++; $display("FAIL b2b_count state=%b stall=%h exp 01/0002", State, StallCount);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    tick();
    idle_inputs();
    tick();
    EX_Redirect = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    total++;
    if (FlushCount !== 16'hFFFF) begin
      bad++; $display("FAIL sat_reach flush=%h exp ffff", FlushCount);
    end
    tick();
    total++;
    if (FlushCount !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold flush=%h exp ffff", FlushCount);
    end
    EX_Redirect = 1'b0;
    tick();
    set_load_use();
    CntClear = 1'b1;
    total++;
    if (StallCount !== 16'd1) begin
      bad++; $display("FAIL clr_pre stall=%h exp 0001", StallCount);
    end
    tick();
    total++;
    if (StallCount !== 16'd0 || FlushCount !== 16'd0 || State !== 2'b01) begin
      bad++; $display("FAIL clr_prio stall=%h flush=%h state=%b exp 0000/0000/01", StallCount, FlushCount, State);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    test_reset();
    test_load_use();
    test_gating();
    test_redirect_load_use();
    test_membusy_hold();
    test_reset_in_hold();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
